rr_merge4: RTL
==============

Name: rr_merge4

Overview:
- 4-to-1 round-robin stream merger; the gather counterpart of the 1-to-4 demux.
- Merges four valid/ready input channels into one registered output stream.
- Tags each output beat with its source index on out_sel. out_sel uses the same 2-bit encoding as the demux select, so a downstream demux can re-route the beat.
- Packet-aware: once a channel starts a multi-beat packet, it holds the grant until its last beat.

Parameters:
DATA_W, 8, payload width per beat

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  4  per-channel beat valid; bit i = channel i
in_ready  output  4  per-channel accept; combinational
in_data  input  4*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
in_last  input  4  per-channel end-of-packet flag, qualified by in_valid
out_valid  output  1  registered output beat valid
out_ready  input  1  downstream accept
out_data  output  DATA_W  registered payload
out_last  output  1  registered end-of-packet flag
out_sel  output  2  registered source channel index (00..11)

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- Reset values: out_valid=0, out_data=0, out_last=0, out_sel=2'b00, state=IDLE, rr_ptr=2'b11, lock_ch=2'b00.
- rr_ptr=3 at reset means channel 0 has top priority on the first arbitration.
- While rst=1, in_ready=4'b0000. rst overrides every other event in that cycle.
- load = ~out_valid | out_ready. This is a single output register with full throughput: 1 beat/cycle when out_ready is held high.
- Latency: an input beat accepted in cycle N appears on the out_* signals in cycle N+1.
- Output hold: while out_valid=1 and out_ready=0, out_data, out_last and out_sel must not change and in_ready must be 4'b0000.
- A transfer on channel i occurs when in_valid[i] & in_ready[i]. At most one in_ready bit is high in any cycle.
- State IDLE:
  - grant = first index with in_valid set, searching rr_ptr+1, rr_ptr+2, rr_ptr+3, rr_ptr (mod 4).
  - If any in_valid and load: in_ready[grant]=1. Capture in_data/in_last of the granted channel; out_sel<=grant; out_valid<=1; rr_ptr<=grant.
  - If the captured in_last=0: go to LOCK with lock_ch<=grant. Otherwise stay in IDLE.
  - No in_valid and load: out_valid<=0 and all in_ready=0.
- State LOCK:
  - Only lock_ch is served: in_ready[lock_ch]=load, all other bits 0.
  - When lock_ch is not valid, a bubble occurs (out_valid<=0 if load) and the grant is kept. Other requesters wait.
  - A transfer with in_last=1 returns to IDLE. rr_ptr stays at lock_ch, so the next arbitration starts at lock_ch+1.
- Wrap-around: rr_ptr increments mod 4 (3 -> 0). A single requester may be granted on back-to-back packets.
- Simultaneous events: if out_ready and a new grant occur in the same cycle, the old beat retires and the new beat loads in that cycle with no bubble.
- Reset mid-packet: the state returns to IDLE and any partially forwarded packet is abandoned. No beats are replayed.
- Single-beat packets (in_last=1 on the first beat) never enter LOCK.

Decomposition:
- Shared package rr_merge4_pkg holds:
  - state encoding constants ST_IDLE=1'b0, ST_LOCK=1'b1
  - NUM_CH=4 and SEL_W=2
- One sub-module is natural: rr_arb4. It is combinational: inputs req[3:0] and ptr[1:0]; outputs gnt_idx[1:0] and gnt_any. It implements the rotated priority search, keeping the arbitration logic separate from the datapath and FSM.

Test Plan:
- Reset, then a single beat on ch2 (data 8'hA5, last=1, out_ready=1) -> in_ready=4'b0100 the same cycle; next cycle out_valid=1, out_data=A5, out_sel=10, out_last=1.
- All four channels hold single-beat packets (data 8'h10..8'h13), out_ready=1 -> out_sel sequence 00,01,10,11,00 on consecutive cycles with no bubbles.
- ch1 sends a 3-beat packet (last on beat 3) while ch0 and ch3 also request -> out_sel=01 for three beats. After that the grant goes to ch3 (rr from 01). ch0 sees in_ready=0 throughout the ch1 packet.
- Backpressure: out_ready=0 for 4 cycles with out_valid=1 -> out_data/out_sel/out_last stable and in_ready=0000. Releasing out_ready resumes flow with no lost or duplicated beats.
- Bubble in LOCK: ch0 drops in_valid mid-packet while ch2 requests -> out_valid=0 for the gap cycles, ch2 not granted until ch0 delivers last=1.
- rst asserted in LOCK (ch3 mid-packet) -> next cycle out_valid=0, state IDLE, rr_ptr=11. A subsequent ch0/ch3 contention grants ch0 first.

Source files
------------

// File: rtl/rr_merge4_pkg.sv
// Shared constants for the 4-to-1 round-robin stream merger.
package rr_merge4_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_LOCK = 1'b1;

endpackage

// File: rtl/rr_arb4.sv
// Rotated-priority arbiter: grants the first requester after ptr, wrapping back to ptr itself.
module rr_arb4
  import rr_merge4_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              gnt_any
);

  logic [SEL_W-1:0] w_cand;

  // Walk from lowest priority to highest so the last hit is the winner.
  always_comb begin
    gnt_idx = '0;
    w_cand  = '0;
    gnt_any = |req;
    for (int k = int'(NUM_CH); k >= 1; k--) begin
      w_cand = ptr + SEL_W'(k);
      if (req[w_cand]) begin
        gnt_idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/rr_merge4.sv
// 4-to-1 packet-aware round-robin merger with a single full-throughput output register.
module rr_merge4
  import rr_merge4_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [SEL_W-1:0]         out_sel
);

  logic              r_state;
  logic              w_state_nxt;
  logic [SEL_W-1:0]  r_rr_ptr;
  logic [SEL_W-1:0]  r_lock_ch;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;
  logic [SEL_W-1:0]  r_out_sel;

  logic              w_load;
  logic [SEL_W-1:0]  w_gnt_idx;
  logic              w_gnt_any;
  logic [SEL_W-1:0]  w_src;
  logic              w_src_valid;
  logic [DATA_W-1:0] w_src_data;
  logic              w_src_last;
  logic              w_xfer;

  rr_arb4 u_arb (
    .req     (in_valid),
    .ptr     (r_rr_ptr),
    .gnt_idx (w_gnt_idx),
    .gnt_any (w_gnt_any)
  );

  assign w_load      = ~r_out_valid | out_ready;
  // A locked packet owns the mux until its last beat.
  assign w_src       = (r_state == ST_LOCK) ? r_lock_ch : w_gnt_idx;
  assign w_src_valid = in_valid[w_src];
  assign w_src_last  = in_last[w_src];
  assign w_src_data  = in_data[32'(w_src) * DATA_W +: DATA_W];
  assign w_xfer      = ~rst & w_load & w_src_valid;

  always_comb begin
    in_ready = '0;
    if (!rst && w_load && ((r_state == ST_LOCK) || w_gnt_any)) begin
      in_ready[w_src] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_xfer) begin
      w_state_nxt = w_src_last ? ST_IDLE : ST_LOCK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output register, arbitration pointer and lock owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_sel   <= '0;
      r_rr_ptr    <= SEL_W'(NUM_CH - 1);
      r_lock_ch   <= '0;
    end else if (w_load) begin
      r_out_valid <= w_xfer;
      if (w_xfer) begin
        r_out_data <= w_src_data;
        r_out_last <= w_src_last;
        r_out_sel  <= w_src;
        if (r_state == ST_IDLE) begin
          r_rr_ptr  <= w_src;
          r_lock_ch <= w_src;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_sel   = r_out_sel;

endmodule
